// File: rtl/input_stager_if.sv
// Byte handshake between upstream source, input_stager and the downstream counting datapath.
// master is the stager's view; slave is the view of whatever surrounds it.
interface input_stager_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_start;
    logic       done;

    modport master (
        input  in_data,
        input  in_valid,
        input  done,
        output in_ready,
        output out_data,
        output out_start
    );

    modport slave (
        output in_data,
        output in_valid,
        output done,
        input  in_ready,
        input  out_data,
        input  out_start
    );
endinterface

// File: rtl/input_stager.sv
// Circular byte FIFO feeding a counting datapath one byte per run; push-to-out_start is 2 cycles, no bypass.
// in_ready drops when the FIFO is full or in reset; the next byte waits for done from the current run.
module input_stager #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input_stager_if.master           bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               issued_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     level_q, level_d;
    logic [7:0]      out_data_q, out_data_d;
    logic [7:0]      issued_q, issued_d;
    logic [7:0]      mem_q [DEPTH];
    logic            push;
    logic            pop;
    logic            start;

    // Ready depends only on registered occupancy and reset, never on done.
    assign bus.in_ready  = (level_q != FULL) && !rst;
    assign push          = bus.in_valid && bus.in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_start = start;
    assign level         = level_q;
    assign issued_cnt    = issued_q;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        pop        = 1'b0;
        start      = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
                    state_d    = ISSUE;
                    out_data_d = mem_q[rd_ptr_q];
                end
            end
            ISSUE: begin
                start   = 1'b1;
                pop     = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        issued_d = pop  ? issued_q + 8'd1 : issued_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            out_data_q <= 8'h00;
            issued_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            out_data_q <= out_data_d;
            issued_q   <= issued_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_input_stager.sv
// Directed bench for input_stager (DEPTH=4): latency, full backpressure, done timing, reset flush, 257-byte order run.
module tb_input_stager;
    logic       clk;
    logic       rst;
    logic [2:0] level;
    logic [7:0] issued_cnt;

    int errors = 0;
    int checks = 0;
    bit sb_on = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    input_stager_if sif();

    input_stager #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (sif),
        .level      (level),
        .issued_cnt (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb_on && sif.out_start) got_q.push_back(sif.out_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic nc();
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        sif.in_valid = 1'b0;
        sif.in_data  = 8'h00;
        sif.done     = 1'b0;

        // Reset
        nc(); #1 check("rst_in_ready", sif.in_ready, 0);
        nc(); rst = 1'b0;
        #1 check("post_rst_in_ready", sif.in_ready, 1);
        check("post_rst_level", level, 0);
        check("post_rst_start", sif.out_start, 0);
        check("post_rst_data", sif.out_data, 8'h00);
        check("post_rst_issued", issued_cnt, 0);

        // Single byte: out_start two cycles after the push
        nc(); sif.in_valid = 1'b1; sif.in_data = 8'h0A;
        #1 check("t1_c0_ready", sif.in_ready, 1);
        check("t1_c0_level", level, 0);
        nc(); sif.in_valid = 1'b0;
        #1 check("t1_c1_level", level, 1);
        check("t1_c1_start", sif.out_start, 0);
        nc(); #1 check("t1_c2_start", sif.out_start, 1);
        check("t1_c2_data", sif.out_data, 8'h0A);
        check("t1_c2_level", level, 1);
        nc(); #1 check("t1_c3_start", sif.out_start, 0);
        check("t1_c3_level", level, 0);
        check("t1_c3_issued", issued_cnt, 1);

        // Fill while the run is outstanding (WAIT, done low)
        for (int i = 1; i <= 4; i++) begin
            nc(); sif.in_valid = 1'b1; sif.in_data = 8'(i);
            #1 check("fill_ready", sif.in_ready, 1);
            check("fill_level", level, i - 1);
        end
        nc(); sif.in_data = 8'h05;
        #1 check("full_ready", sif.in_ready, 0);
        check("full_level", level, 4);
        nc(); sif.done = 1'b1;
        #1 check("k_ready", sif.in_ready, 0);
        check("k_start", sif.out_start, 0);
        nc(); sif.done = 1'b0;
        #1 check("k1_start", sif.out_start, 0);
        check("k1_level", level, 4);
        nc(); #1 check("k2_start", sif.out_start, 1);
        check("k2_data", sif.out_data, 8'h01);
        check("k2_ready_full_pop", sif.in_ready, 0);
        check("k2_level", level, 4);
        nc(); #1 check("k3_level", level, 3);
        check("k3_ready", sif.in_ready, 1);
        check("k3_issued", issued_cnt, 2);
        nc(); sif.in_valid = 1'b0;
        #1 check("k4_level", level, 4);

        // Drain one byte per done pulse, in arrival order
        for (int b = 2; b <= 5; b++) begin
            nc(); sif.done = 1'b1;
            #1 check("drain_wait_start", sif.out_start, 0);
            nc(); sif.done = 1'b0;
            #1 check("drain_idle_start", sif.out_start, 0);
            nc(); #1 check("drain_start", sif.out_start, 1);
            check("drain_data", sif.out_data, 8'(b));
        end
        nc(); sif.done = 1'b1;
        #1 check("drain_issued", issued_cnt, 6);
        check("drain_level", level, 0);
        nc(); sif.done = 1'b0;
        nc(); #1 check("hold_start", sif.out_start, 0);
        check("hold_data", sif.out_data, 8'h05);

        // Push and pop in the same ISSUE cycle
        nc(); sif.in_valid = 1'b1; sif.in_data = 8'hA1;
        nc(); sif.in_data = 8'hA2;
        nc(); sif.in_data = 8'hA3;
        #1 check("pp_start", sif.out_start, 1);
        check("pp_level", level, 2);
        check("pp_wr_before", dut.wr_ptr_q, 0);
        check("pp_rd_before", dut.rd_ptr_q, 2);
        nc(); sif.in_data = 8'hA4;
        #1 check("pp_level_after", level, 2);
        check("pp_wr_after", dut.wr_ptr_q, 1);
        check("pp_rd_after", dut.rd_ptr_q, 3);
        check("pp_data", sif.out_data, 8'hA1);

        // Reset in WAIT with three bytes stored
        nc(); sif.in_valid = 1'b0; rst = 1'b1;
        #1 check("wr_rst_level", level, 3);
        check("wr_rst_ready", sif.in_ready, 0);
        nc(); rst = 1'b0; sif.done = 1'b1;
        #1 check("ar_level", level, 0);
        check("ar_ready", sif.in_ready, 1);
        check("ar_data", sif.out_data, 8'h00);
        check("ar_issued", issued_cnt, 0);
        check("ar_start", sif.out_start, 0);
        nc(); sif.done = 1'b0;
        #1 check("ar_done_start1", sif.out_start, 0);
        nc(); #1 check("ar_done_start2", sif.out_start, 0);
        check("ar_level2", level, 0);

        // 257 bytes against a scoreboard, random done delay 0..2 WAIT cycles
        nc();
        sb_on = 1'b1;
        fork
            begin : source
                int  bud;
                bit  acc;
                bit  to;
                bud = 0;
                to  = 1'b0;
                for (int i = 0; i < 257 && !to; i++) begin
                    sif.in_valid = 1'b1;
                    sif.in_data  = 8'(i ^ 8'h5A);
                    acc = 1'b0;
                    while (!acc && !to) begin
                        #1;
                        if (sif.in_ready) begin
                            acc = 1'b1;
                            exp_q.push_back(sif.in_data);
                        end
                        @(negedge clk);
                        bud++;
                        if (bud > 5000) to = 1'b1;
                    end
                end
                sif.in_valid = 1'b0;
                check("src_budget", {31'd0, to}, 0);
            end
            begin : responder
                int n;
                int bud;
                int d;
                n   = 0;
                bud = 0;
                while (n < 257 && bud < 6000) begin
                    @(negedge clk);
                    bud++;
                    #1;
                    if (sif.out_start) begin
                        n++;
                        d = $urandom_range(0, 2);
                        repeat (d) @(negedge clk);
                        @(negedge clk);
                        sif.done = 1'b1;
                        @(negedge clk);
                        sif.done = 1'b0;
                    end
                end
                check("resp_issues", n, 257);
            end
        join
        repeat (6) nc();
        sb_on = 1'b0;
        #1 check("sb_got_count", got_q.size(), 257);
        check("sb_exp_count", exp_q.size(), 257);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                if (got_q[i] !== exp_q[i]) bad++;
            end
            check("sb_order", bad, 0);
        end
        check("wrap_issued", issued_cnt, 1);
        check("wrap_level", level, 0);
        check("wrap_ready", sif.in_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
